// File: rtl/swervolf_bin2seg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : swervolf_bin2seg                                              |
// | Purpose  : Sequential binary -> packed BCD converter (iterative double-  |
// |            dabble, one bit per clock) with leading-zero blanking and     |
// |            overflow indication. Feeds the digit/enable registers of the  |
// |            eight-digit seven-segment controller.                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   i_clk       in   1          system clock                               |
// |   i_rst       in   1          synchronous, active-high reset             |
// |   i_start     in   1          conversion request, sampled only in IDLE   |
// |   i_bin       in   BIN_W      unsigned value, captured on accepted start |
// |   i_lz_blank  in   1          leading-zero blanking, captured on start   |
// |   o_busy      out  1          conversion in progress                     |
// |   o_done      out  1          one-cycle pulse when results update        |
// |   o_bcd       out  4*N_DIGITS packed BCD, digit 0 in bits [3:0]          |
// |   o_enables   out  N_DIGITS   active-low digit enables                   |
// |   o_overflow  out  1          last accepted value exceeded 99_999_999    |
// +--------------------------------------------------------------------------+

module swervolf_bin2seg #(
  parameter int BIN_W    = 27,
  parameter int N_DIGITS = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_bin,
  input  logic                  i_lz_blank,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*N_DIGITS-1:0] o_bcd,
  output logic [N_DIGITS-1:0]   o_enables,
  output logic                  o_overflow
);

  localparam int                  c_bcd_w   = 4 * N_DIGITS;
  localparam int                  c_cnt_w   = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0]    c_max_val = BIN_W'(99_999_999);
  // Reset display: a single "0" on digit 0, all other digits dark.
  localparam logic [N_DIGITS-1:0] c_en_rst  = {{(N_DIGITS-1){1'b1}}, 1'b0};
  localparam logic [c_bcd_w-1:0]  c_bcd_ovf = {N_DIGITS{4'hE}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t               state_q,   state_d;
  logic [BIN_W-1:0]     bin_q,     bin_d;
  logic [c_bcd_w-1:0]   scratch_q, scratch_d;
  logic [c_cnt_w-1:0]   cnt_q,     cnt_d;
  logic                 blank_q,   blank_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;
  logic [c_bcd_w-1:0]   bcd_q,     bcd_d;
  logic [N_DIGITS-1:0]  en_q,      en_d;
  logic                 ovf_q,     ovf_d;

  logic [c_bcd_w-1:0]   w_adj;
  logic [c_bcd_w-1:0]   w_shift;
  logic [N_DIGITS-1:0]  w_en_blank;
  logic                 w_scratch_ok;

  // Double-dabble step: add 3 to every digit >= 5 (digits are independent,
  // no carry crosses a nibble), then shift the next binary MSB in.
  always_comb begin
    w_adj = scratch_q;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    w_shift = {w_adj[c_bcd_w-2:0], bin_q[BIN_W-1]};
  end

  // Blanking mask for the final digits: bit i goes dark only when digit i
  // and every digit above it are zero. Digit 0 always stays lit.
  always_comb begin
    logic zero_run;
    zero_run   = 1'b1;
    w_en_blank = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run & (w_shift[4*i +: 4] == 4'd0);
      w_en_blank[i] = zero_run;
    end
  end

  // Next-state and datapath.
  // Results, o_done and o_busy are registered on the transition into their
  // state, so o_done and the new result appear together in the FINISH cycle.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    blank_d   = blank_q;
    bcd_d     = bcd_q;
    en_d      = en_q;
    ovf_d     = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          blank_d = i_lz_blank;
          if (i_bin > c_max_val) begin
            // Out of display range: skip the shift phase entirely.
            bcd_d   = c_bcd_ovf;
            en_d    = '0;
            ovf_d   = 1'b1;
            state_d = ST_FINISH;
          end else begin
            scratch_d = '0;
            bin_d     = i_bin;
            cnt_d     = c_cnt_w'(BIN_W);
            state_d   = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        scratch_d = w_shift;
        bin_d     = bin_q << 1;
        cnt_d     = cnt_q - c_cnt_w'(1);
        if (cnt_q == c_cnt_w'(1)) begin
          // Last iteration: publish the fully shifted scratch directly.
          bcd_d   = w_shift;
          en_d    = blank_q ? w_en_blank : '0;
          ovf_d   = 1'b0;
          state_d = ST_FINISH;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_FINISH);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      blank_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      en_q      <= c_en_rst;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      blank_q   <= blank_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      en_q      <= en_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_bcd      = bcd_q;
  assign o_enables  = en_q;
  assign o_overflow = ovf_q;

  // Every scratch digit must remain a legal decimal digit.
  always_comb begin
    w_scratch_ok = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (scratch_q[4*i +: 4] > 4'd9) begin
        w_scratch_ok = 1'b0;
      end
    end
  end

  a_scratch_digits: assert property (@(posedge i_clk) disable iff (i_rst) w_scratch_ok);
  a_done_single:    assert property (@(posedge i_clk) disable iff (i_rst) o_done |=> !o_done);

endmodule

`default_nettype wire

// File: tb/tb_swervolf_bin2seg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_swervolf_bin2seg                                           |
// | Purpose  : Self-checking bench for swervolf_bin2seg. Expected results    |
// |            are queued at start time and compared when o_done pulses.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

module tb_swervolf_bin2seg;

  localparam int BIN_W = 27;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [BIN_W-1:0]  bin;
  logic              blank;
  logic              busy;
  logic              done;
  logic [31:0]       bcd;
  logic [7:0]        en;
  logic              ovf;

  swervolf_bin2seg #(.BIN_W(BIN_W), .N_DIGITS(8)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_bin      (bin),
    .i_lz_blank (blank),
    .o_busy     (busy),
    .o_done     (done),
    .o_bcd      (bcd),
    .o_enables  (en),
    .o_overflow (ovf)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] bcd;
    logic [7:0]  en;
    logic        ovf;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];
  int   errors    = 0;
  int   checks    = 0;
  int   done_seen = 0;
  logic prev_done = 1'b0;

  // Reference: decimal digits by division, blanking from the digit values.
  function automatic exp_t model(input logic [BIN_W-1:0] v, input logic bl,
                                 input int unsigned c);
    exp_t        e;
    int unsigned x;
    logic        z;
    e.cyc = c;
    e.bcd = '0;
    e.en  = '0;
    if (v > 99_999_999) begin
      e.bcd = 32'hEEEE_EEEE;
      e.ovf = 1'b1;
    end else begin
      e.ovf = 1'b0;
      x = v;
      for (int i = 0; i < 8; i++) begin
        e.bcd[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
      if (bl) begin
        z = 1'b1;
        for (int i = 7; i >= 1; i--) begin
          z = z & (e.bcd[4*i +: 4] == 4'd0);
          e.en[i] = z;
        end
      end
    end
    return e;
  endfunction

  // Result monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done === 1'b1) begin
      done_seen = done_seen + 1;
      checks++;
      if (prev_done === 1'b1) begin
        errors++;
        $display("FAIL done_consecutive: o_done high two cycles in a row at cycle %0d", cyc);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: o_done at cycle %0d with no result expected (bcd=%h)", cyc, bcd);
      end else begin
        e = sb.pop_front();
        checks++;
        if (bcd !== e.bcd) begin
          errors++;
          $display("FAIL result_bcd: got %h expected %h", bcd, e.bcd);
        end
        checks++;
        if (en !== e.en) begin
          errors++;
          $display("FAIL result_enables: got %h expected %h", en, e.en);
        end
        checks++;
        if (ovf !== e.ovf) begin
          errors++;
          $display("FAIL result_overflow: got %b expected %b", ovf, e.ovf);
        end
        checks++;
        if (cyc !== e.cyc) begin
          errors++;
          $display("FAIL result_latency: o_done at cycle %0d expected cycle %0d", cyc, e.cyc);
        end
      end
    end
    prev_done <= done;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a one-cycle start pulse in the current cycle N; on acceptance the
  // result is expected at N+28 (normal) or N+1 (overflow).
  task automatic pulse_start(input logic [BIN_W-1:0] v, input logic bl, input logic accept);
    int unsigned lat;
    lat   = (v > 99_999_999) ? 1 : BIN_W + 1;
    bin   = v;
    blank = bl;
    start = 1'b1;
    if (accept) sb.push_back(model(v, bl, cyc + lat));
    step(1);
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step(1);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results still pending after %0d cycles", sb.size(), n);
      sb.delete();
    end
    step(2);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bin = '0; blank = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);
    checks++; if (bcd !== 32'h0) begin errors++; $display("FAIL reset_bcd: got %h expected 00000000", bcd); end
    checks++; if (en !== 8'hFE) begin errors++; $display("FAIL reset_enables: got %h expected fe", en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", ovf); end
  endtask

  task automatic test_zero();
    pulse_start(27'd0, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_busy_window();
    pulse_start(27'd12_345_678, 1'b1, 1'b1);
    // Now in cycle N+1: busy must cover N+1..N+27, low at N+28.
    for (int k = 1; k <= BIN_W; k++) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_window: busy=%b at N+%0d expected 1", busy, k);
      end
      step(1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_drop: busy=%b at N+28 expected 0", busy);
    end
    drain();
  endtask

  task automatic test_blanking();
    pulse_start(27'd1000, 1'b1, 1'b1);
    drain();
    pulse_start(27'd1000, 1'b0, 1'b1);
    drain();
    pulse_start(27'd7, 1'b1, 1'b1);
    drain();
    pulse_start(27'd10_000_000, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_overflow();
    pulse_start(27'd99_999_999, 1'b1, 1'b1);
    drain();
    pulse_start(27'd100_000_000, 1'b1, 1'b1);
    drain();
    pulse_start(27'h7FF_FFFF, 1'b0, 1'b1);
    drain();
    pulse_start(27'd98_765_432, 1'b0, 1'b1);
    drain();
  endtask

  task automatic test_ignored_start();
    int base;
    base = done_seen;
    pulse_start(27'd42, 1'b1, 1'b1);      // accepted at N, now N+1
    step(4);                              // N+5
    pulse_start(27'd7, 1'b0, 1'b0);       // ignored while busy
    bin = 27'd555;
    blank = 1'b0;
    step(21);                             // N+27
    step(1);                              // N+28: FINISH cycle
    pulse_start(27'd9, 1'b1, 1'b0);       // ignored in FINISH
    step(35);
    checks++;
    if (done_seen - base !== 1) begin
      errors++;
      $display("FAIL ignored_start: %0d o_done pulses, expected 1", done_seen - base);
    end
    drain();
  endtask

  task automatic test_reset_abort();
    int base;
    base = done_seen;
    pulse_start(27'd9999, 1'b1, 1'b0);    // aborted; no result expected
    step(9);                              // N+10
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++; if (bcd !== 32'h0) begin errors++; $display("FAIL abort_bcd: got %h expected 00000000", bcd); end
    checks++; if (en !== 8'hFE) begin errors++; $display("FAIL abort_enables: got %h expected fe", en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    step(40);
    checks++;
    if (done_seen - base !== 0) begin
      errors++;
      $display("FAIL abort_done: %0d o_done pulses after abort, expected 0", done_seen - base);
    end
    pulse_start(27'd5, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    int unsigned n0;
    n0    = cyc;
    start = 1'b1;
    blank = 1'b1;
    bin   = 27'd111;
    sb.push_back(model(27'd111, 1'b1, n0 + 28));
    step(1);
    bin = 27'd2_222;
    sb.push_back(model(27'd2_222, 1'b1, n0 + 29 + 28));
    step(29);
    bin = 27'd33_333_333;
    sb.push_back(model(27'd33_333_333, 1'b1, n0 + 58 + 28));
    step(29);
    start = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_zero();
    test_busy_window();
    test_blanking();
    test_overflow();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
